// File: rtl/loctag_phy_core_pkg.sv
// rtl/loctag_phy_core_pkg.sv - shared constants and CRC step for the LocTag PHY helper
package loctag_phy_core_pkg;

  localparam logic [31:0] CRC32_POLY     = 32'h04C11DB7;
  localparam int          SCR_TAP_A      = 4;
  localparam int          SCR_TAP_B      = 7;
  localparam int          ADC_FRAME_BITS = 16;
  localparam int          ADC_DATA_FIRST = 5;
  localparam int          ADC_DATA_LAST  = 12;

  // Linear CRC-32 step: no preset, no final complement.
  function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[31];
    return {crc[30:0], 1'b0} ^ (fb ? CRC32_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/loctag_phy_core_if.sv
// rtl/loctag_phy_core_if.sv - pin and strobe bundle between tag controller and PHY core
interface loctag_phy_core_if;
  logic       adc_start;
  logic       adc_cs;
  logic       adc_sclk;
  logic       adc_so;
  logic       adc_eoc;
  logic [7:0] adc_data;
  logic       bit_tick;
  logic       mod_enable;
  logic       mod_s_in;
  logic       mod_s_out;
  logic       fcs_tick;
  logic       fcs_enable;
  logic       fcs_s_in;
  logic [31:0] fcs_val;

  modport master (
    output adc_start, adc_so, bit_tick, mod_enable, mod_s_in, fcs_tick, fcs_enable, fcs_s_in,
    input  adc_cs, adc_sclk, adc_eoc, adc_data, mod_s_out, fcs_val
  );

  modport slave (
    input  adc_start, adc_so, bit_tick, mod_enable, mod_s_in, fcs_tick, fcs_enable, fcs_s_in,
    output adc_cs, adc_sclk, adc_eoc, adc_data, mod_s_out, fcs_val
  );
endinterface

// File: rtl/loctag_phy_core_adc_serial_rx.sv
// rtl/loctag_phy_core_adc_serial_rx.sv - AD7478 8-bit serial reader FSM
module adc_serial_rx
  import loctag_phy_core_pkg::*;
#(
  parameter int unsigned SCLK_HALF = 2,
  parameter int unsigned CS_QUIET  = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       so_i,
  output logic       cs_o,
  output logic       sclk_o,
  output logic       eoc_o,
  output logic [7:0] data_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CONV  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_QUIET = 2'd3;

  localparam logic [7:0] HALF_LAST  = 8'(SCLK_HALF - 1);
  localparam logic [7:0] QUIET_LAST = 8'(CS_QUIET - 1);
  localparam logic [4:0] EDGE_LAST  = 5'(2 * ADC_FRAME_BITS - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [4:0] edge_q, edge_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       cs_q, cs_d, sclk_q, sclk_d, eoc_q, eoc_d;
  logic [4:0] rise_num;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    edge_d   = edge_q;
    shift_d  = shift_q;
    data_d   = data_q;
    cs_d     = cs_q;
    sclk_d   = sclk_q;
    eoc_d    = 1'b0;
    rise_num = {1'b0, edge_q[4:1]} + 5'd1;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_CONV;
          cs_d    = 1'b0;
          sclk_d  = 1'b0;
          cnt_d   = '0;
          edge_d  = '0;
        end
      end
      S_CONV: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          edge_d = edge_q + 5'd1;
          // Rising SCLK edges carry bits 1..16; keep only the D7..D0 window.
          if (!sclk_q && rise_num >= 5'(ADC_DATA_FIRST) && rise_num <= 5'(ADC_DATA_LAST))
            shift_d = {shift_q[6:0], so_i};
          if (edge_q == EDGE_LAST) begin
            state_d = S_DONE;
            cs_d    = 1'b1;
            sclk_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        eoc_d   = 1'b1;
        data_d  = shift_q;
        cnt_d   = '0;
        state_d = S_QUIET;
      end
      S_QUIET: begin
        if (cnt_q == QUIET_LAST) begin
          if (start_i) begin
            state_d = S_CONV;
            cs_d    = 1'b0;
            sclk_d  = 1'b0;
            cnt_d   = '0;
            edge_d  = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      edge_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b1;
      eoc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      eoc_q   <= eoc_d;
    end
  end

  assign cs_o   = cs_q;
  assign sclk_o = sclk_q;
  assign eoc_o  = eoc_q;
  assign data_o = data_q;

endmodule

// File: rtl/loctag_phy_core.sv
// rtl/loctag_phy_core.sv - LocTag PHY helper: ADC reader, DBPSK XOR modulator, linear FCS
module loctag_phy_core
  import loctag_phy_core_pkg::*;
#(
  parameter int unsigned SCLK_HALF = 2,
  parameter int unsigned CS_QUIET  = 4
) (
  input logic              clk_i,
  input logic              reset_i,
  loctag_phy_core_if.slave bus
);

  adc_serial_rx #(
    .SCLK_HALF(SCLK_HALF),
    .CS_QUIET (CS_QUIET)
  ) u_adc (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .start_i(bus.adc_start),
    .so_i   (bus.adc_so),
    .cs_o   (bus.adc_cs),
    .sclk_o (bus.adc_sclk),
    .eoc_o  (bus.adc_eoc),
    .data_o (bus.adc_data)
  );

  logic [6:0]  sc_q, sc_d;
  logic        p_q, p_d, scr_bit;
  logic [31:0] crc_q, crc_d;
  logic        first_q, first_d;

  // sc[0] holds s(k-1), so tap n reads sc[n-1].
  always_comb begin
    scr_bit = bus.mod_s_in ^ sc_q[SCR_TAP_A-1] ^ sc_q[SCR_TAP_B-1];
    sc_d    = sc_q;
    p_d     = p_q;
    if (!bus.mod_enable) begin
      sc_d = '0;
      p_d  = 1'b0;
    end else if (bus.bit_tick) begin
      sc_d = {sc_q[5:0], scr_bit};
      p_d  = p_q ^ scr_bit;
    end
  end

  // crc_q is held while disabled; first_q makes the next run start from zero.
  always_comb begin
    crc_d   = crc_q;
    first_d = first_q;
    if (!bus.fcs_enable) begin
      first_d = 1'b1;
    end else if (bus.fcs_tick) begin
      crc_d   = crc32_step(first_q ? 32'h0 : crc_q, bus.fcs_s_in);
      first_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sc_q    <= '0;
      p_q     <= 1'b0;
      crc_q   <= '0;
      first_q <= 1'b1;
    end else begin
      sc_q    <= sc_d;
      p_q     <= p_d;
      crc_q   <= crc_d;
      first_q <= first_d;
    end
  end

  assign bus.mod_s_out = bus.mod_enable & p_q;
  assign bus.fcs_val   = crc_q;

endmodule

// File: tb/tb_loctag_phy_core.sv
// tb/tb_loctag_phy_core.sv - scoreboard bench for loctag_phy_core
module tb_loctag_phy_core;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #10 clk = ~clk;

  loctag_phy_core_if bus();

  loctag_phy_core #(.SCLK_HALF(2), .CS_QUIET(4)) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // AD7478 model: bit n of the frame is presented before the n-th SCLK rise
  logic [15:0] frame_q[$];
  logic [15:0] cur_frame = '0;
  int          rise_cnt = 0;

  always @(negedge bus.adc_cs) begin
    cur_frame = (frame_q.size() != 0) ? frame_q.pop_front() : 16'h0;
    rise_cnt  = 0;
  end
  always @(posedge bus.adc_sclk) if (!bus.adc_cs) rise_cnt++;
  assign bus.adc_so = (rise_cnt < 16) ? cur_frame[15 - rise_cnt] : 1'b0;

  logic [7:0]  adc_exp_q[$];
  logic        mod_exp_q[$];
  logic [31:0] fcs_exp_q[$];

  int low_run = 0, high_run = 0, eoc_cnt = 0, fall_cnt = 0, sclk_bad = 0;
  int low_lens[$];
  int gap_lens[$];

  always @(negedge clk) begin
    if (reset) begin
      low_run  = 0;
      high_run = 0;
    end else if (!bus.adc_cs) begin
      if (low_run == 0) begin
        gap_lens.push_back(high_run);
        fall_cnt++;
      end
      low_run++;
      high_run = 0;
    end else begin
      if (low_run != 0) low_lens.push_back(low_run);
      low_run = 0;
      high_run++;
      if (!bus.adc_sclk) sclk_bad++;
    end
    if (bus.adc_eoc) begin
      eoc_cnt++;
      if (adc_exp_q.size() == 0) check_val("adc_eoc_unexpected", 32'd1, 32'd0);
      else check_val("adc_data", {24'h0, bus.adc_data}, {24'h0, adc_exp_q.pop_front()});
    end
  end

  task automatic wait_eoc(input int target, input int limit);
    int t = 0;
    while (eoc_cnt < target && t < limit) begin
      cyc(1);
      t++;
    end
    if (eoc_cnt < target) check_val("adc_eoc_timeout", eoc_cnt, target);
  endtask

  logic s_hist[$];
  logic m_p = 1'b0;
  logic [31:0] crc_m = '0;

  function automatic logic mod_model(input logic din);
    logic s4, s7, s;
    int n;
    n  = s_hist.size();
    s4 = (n >= 4) ? s_hist[n-4] : 1'b0;
    s7 = (n >= 7) ? s_hist[n-7] : 1'b0;
    s  = din ^ s4 ^ s7;
    s_hist.push_back(s);
    m_p = m_p ^ s;
    return m_p;
  endfunction

  function automatic logic [31:0] crc_model(input logic din);
    crc_m = (crc_m << 1) ^ ({32{din ^ crc_m[31]}} & 32'h04C11DB7);
    return crc_m;
  endfunction

  task automatic mod_step(input logic din, input logic exp_bit);
    bus.mod_s_in = din;
    bus.bit_tick = 1'b1;
    mod_exp_q.push_back(exp_bit);
    cyc(1);
    bus.bit_tick = 1'b0;
    check_val("mod_s_out", bus.mod_s_out, mod_exp_q.pop_front());
    cyc(1);
    check_val("mod_hold", bus.mod_s_out, exp_bit);
  endtask

  task automatic fcs_step(input logic din, input logic [31:0] exp);
    bus.fcs_s_in = din;
    bus.fcs_tick = 1'b1;
    fcs_exp_q.push_back(exp);
    cyc(1);
    bus.fcs_tick = 1'b0;
    check_val("fcs_val", bus.fcs_val, fcs_exp_q.pop_front());
  endtask

  int imp_exp[9] = '{1, 1, 1, 1, 0, 0, 0, 1, 0};

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int e;
    logic din, em;
    logic [31:0] ef;

    bus.adc_start  = 1'b0;
    bus.bit_tick   = 1'b0;
    bus.mod_enable = 1'b0;
    bus.mod_s_in   = 1'b0;
    bus.fcs_tick   = 1'b0;
    bus.fcs_enable = 1'b0;
    bus.fcs_s_in   = 1'b0;
    cyc(3);
    check_val("rst_adc_cs", bus.adc_cs, 1);
    check_val("rst_adc_sclk", bus.adc_sclk, 1);
    check_val("rst_adc_eoc", bus.adc_eoc, 0);
    check_val("rst_adc_data", bus.adc_data, 0);
    check_val("rst_mod_s_out", bus.mod_s_out, 0);
    check_val("rst_fcs_val", bus.fcs_val, 0);
    reset = 1'b0;
    cyc(2);

    // ADC: two back-to-back conversions, start dropped during the second
    frame_q.push_back({4'h0, 8'hA5, 4'h0});
    adc_exp_q.push_back(8'hA5);
    frame_q.push_back({4'h0, 8'h3C, 4'h0});
    adc_exp_q.push_back(8'h3C);
    bus.adc_start = 1'b1;
    wait_eoc(1, 300);
    t = 0;
    while (bus.adc_cs && t < 20) begin
      cyc(1);
      t++;
    end
    check_val("adc_second_cs_fall", bus.adc_cs, 0);
    bus.adc_start = 1'b0;
    wait_eoc(2, 200);
    cyc(100);
    check_val("adc_conv_count", fall_cnt, 2);
    check_val("adc_data_held", bus.adc_data, 8'h3C);
    check_val("adc_cs_low_runs", low_lens.size(), 2);
    if (low_lens.size() >= 2) begin
      check_val("adc_cs_low_len0", low_lens[0], 64);
      check_val("adc_cs_low_len1", low_lens[1], 64);
    end
    check_val("adc_gap_runs", gap_lens.size(), 2);
    if (gap_lens.size() >= 2) check_val("adc_cs_gap_ge4", gap_lens[1] >= 4, 1);
    check_val("adc_sclk_idle_high", sclk_bad, 0);

    // ADC: reset during a conversion
    frame_q.push_back({4'h0, 8'hFF, 4'h0});
    bus.adc_start = 1'b1;
    cyc(20);
    check_val("adc_cs_mid_conv", bus.adc_cs, 0);
    reset = 1'b1;
    bus.adc_start = 1'b0;
    cyc(1);
    check_val("adc_reset_cs", bus.adc_cs, 1);
    check_val("adc_reset_sclk", bus.adc_sclk, 1);
    reset = 1'b0;
    e = eoc_cnt;
    cyc(150);
    check_val("adc_no_eoc_after_reset", eoc_cnt, e);
    check_val("adc_data_after_reset", bus.adc_data, 0);
    frame_q.delete();

    // Modulator impulse, zero input, clear mid-stream
    bus.mod_enable = 1'b1;
    for (int i = 0; i < 9; i++) mod_step(i == 0, 1'(imp_exp[i]));
    bus.mod_enable = 1'b0;
    cyc(1);
    check_val("mod_clear", bus.mod_s_out, 0);
    bus.mod_enable = 1'b1;
    for (int i = 0; i < 10; i++) mod_step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) mod_step(i == 0, 1'(imp_exp[i]));
    bus.mod_enable = 1'b0;
    bus.mod_s_in = 1'b1;
    bus.bit_tick = 1'b1;
    cyc(1);
    bus.bit_tick = 1'b0;
    check_val("mod_tick_disabled", bus.mod_s_out, 0);
    bus.mod_enable = 1'b1;
    for (int i = 0; i < 9; i++) mod_step(i == 0, 1'(imp_exp[i]));

    // FCS single bits, hold, restart
    bus.fcs_enable = 1'b1;
    fcs_step(1'b1, 32'h04C11DB7);
    fcs_step(1'b0, 32'h09823B6E);
    bus.fcs_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.fcs_s_in = 1'b1;
      bus.fcs_tick = 1'b1;
      cyc(1);
      bus.fcs_tick = 1'b0;
      check_val("fcs_hold", bus.fcs_val, 32'h09823B6E);
    end
    bus.fcs_enable = 1'b1;
    cyc(2);
    check_val("fcs_hold_no_tick", bus.fcs_val, 32'h09823B6E);
    fcs_step(1'b1, 32'h04C11DB7);

    // Both engines on one random stream with coincident ticks
    bus.mod_enable = 1'b0;
    bus.fcs_enable = 1'b0;
    cyc(1);
    bus.mod_enable = 1'b1;
    bus.fcs_enable = 1'b1;
    s_hist.delete();
    m_p = 1'b0;
    crc_m = '0;
    for (int i = 0; i < 24; i++) begin
      din = 1'($urandom_range(0, 1));
      bus.mod_s_in = din;
      bus.fcs_s_in = din;
      bus.bit_tick = 1'b1;
      bus.fcs_tick = 1'b1;
      em = mod_model(din);
      ef = crc_model(din);
      mod_exp_q.push_back(em);
      fcs_exp_q.push_back(ef);
      cyc(1);
      bus.bit_tick = 1'b0;
      bus.fcs_tick = 1'b0;
      check_val("mod_stream", bus.mod_s_out, mod_exp_q.pop_front());
      check_val("fcs_stream", bus.fcs_val, fcs_exp_q.pop_front());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/loctag_phy_core.md
# loctag_phy_core

Bit-level physical-layer helper for the LocTag backscatter tag, sitting between the tag control FSM and the ADC / RF-switch pins. It contains three independent engines on one 50 MHz clock:
- an AD7478 8-bit serial ADC reader used for RSS capture;
- an 802.11b 1 Mbps XOR-pattern modulator (differential scrambler plus DBPSK encoder) that drives the reflection-switch inversion;
- a linear CRC-32 engine that produces the FCS correction word for the XOR pattern.

## Interface
Parameters:
- SCLK_HALF, 2, clk cycles per ADC SCLK half-period (2 gives 12.5 MHz).
- CS_QUIET, 4, clk cycles CS stays high between back-to-back conversions.

Ports:
- clk  in  1  50 MHz system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- adc_start  in  1  level; while high, conversions repeat back-to-back.
- adc_cs  out  1  AD7478 chip select, active low.
- adc_sclk  out  1  AD7478 serial clock, idles high.
- adc_so  in  1  AD7478 serial data out.
- adc_eoc  out  1  one-cycle pulse; adc_data is valid from this cycle.
- adc_data  out  8  last converted sample; held until the next eoc.
- bit_tick  in  1  one-cycle strobe at 1 µs bit rate (modulator step).
- mod_enable  in  1  modulator run; low clears state.
- mod_s_in  in  1  XOR-pattern data bit, LSB-first per byte.
- mod_s_out  out  1  phase-inversion bit for the RF switch.
- fcs_tick  in  1  one-cycle strobe, 1 µs rate, offset from bit_tick (CRC step).
- fcs_enable  in  1  CRC run.
- fcs_s_in  in  1  same XOR-pattern bit stream as mod_s_in.
- fcs_val  out  32  linear CRC remainder; bit 31 is transmitted first.

## Operation
Reset values: adc_cs=1, adc_sclk=1, adc_eoc=0, adc_data=0, mod_s_out=0, fcs_val=0. Reset aborts any conversion immediately.

ADC FSM states:
- IDLE: waits for adc_start=1.
- CONV: adc_cs low, 16 SCLK cycles; adc_so is sampled on each SCLK rising edge.
  - Bits 1–4 are leading zeros and are discarded.
  - Bits 5–12 are D7..D0, MSB first.
  - Bits 13–16 are trailing zeros and are discarded.
- DONE: adc_cs high; adc_data is loaded and adc_eoc pulses for one cycle.
- QUIET: CS_QUIET cycles, then CONV if adc_start=1, else IDLE.
- adc_start dropping mid-conversion: the current conversion completes.

Modulator (state sc[6:0] and phase p, both cleared when mod_enable=0):
- On each clk with bit_tick & mod_enable:
  - s = mod_s_in ^ sc[3] ^ sc[6], where sc[3] is s(k-4) and sc[6] is s(k-7).
  - Shift s into sc.
  - p = p ^ s; mod_s_out = p.
- mod_enable=0 forces mod_s_out=0.

FCS engine (register crc[31:0]):
- On each fcs_tick & fcs_enable:
  - fb = fcs_s_in ^ crc[31].
  - crc = {crc[30:0],0} ^ (fb ? 32'h04C11DB7 : 0).
- There is no initial 0xFFFFFFFF and no final complement; this is the linear part only.
- The first enabled tick after fcs_enable was low starts from crc=0.
- fcs_val = crc, held while fcs_enable=0 so it can be latched afterwards.

## Timing
- ADC:
  - adc_cs falls one cycle after adc_start is seen in IDLE.
  - Conversion length is 32·SCLK_HALF clk cycles with CS low.
  - adc_eoc occurs one cycle after CS rises (latency 66 clks at default parameters).
  - adc_data and adc_eoc change in the same cycle.
- mod_s_out and fcs_val update on the clock edge where the tick is high, so the new value is visible in the next cycle.
- A tick with enable=0 has no effect besides holding the clear/hold state.
- bit_tick and fcs_tick may coincide in the same cycle; the engines are independent.

## Structure
- Shared package holds:
  - CRC32_POLY=32'h04C11DB7.
  - Scrambler tap positions (4, 7).
  - ADC frame constants: 16 bits, data at bits 5–12.
- Sub-module adc_serial_rx holds the ADC FSM.
- The modulator and FCS engines are inline.

## Test plan
- ADC conversion:
  - Stimulus: adc_start=1 with the serial model returning 0xA5, then 0x3C.
  - Response: eoc pulses carrying 0xA5, then 0x3C.
  - CS low for exactly 64 clks, at least 4 clks high between conversions, SCLK idle high.
- Modulator impulse response:
  - Stimulus: mod_enable=1, mod_s_in = 1 then all 0s, 9 ticks.
  - Response: mod_s_out = 1,1,1,1,0,0,0,1,0.
- Modulator zero input: all-zero input gives mod_s_out=0 throughout.
- Modulator clear: dropping mod_enable mid-stream, then repeating the impulse, reproduces the same sequence.
- FCS single bits: fcs_s_in=1 gives fcs_val=0x04C11DB7; a following 0 gives 0x09823B6E.
- FCS hold and restart:
  - fcs_enable low holds the value.
  - Re-enabling followed by a 1 gives 0x04C11DB7 again.
- Reset mid-conversion: adc_cs=1 and adc_sclk=1 on the next cycle, and no eoc is produced.
